// File: rtl/masked_share_decoder_if.sv
// Valid/ready bus for the masked share decoder: share-pair input side and
// unmasked-word output side.
interface masked_share_decoder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] share0;
    logic [WIDTH-1:0] share1;
    logic [WIDTH-1:0] r;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Producer of share pairs / consumer of decoded words
    modport master (
        output in_valid, share0, share1, r, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The decoder itself
    modport slave (
        input  in_valid, share0, share1, r, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/masked_share_decoder.sv
// Unmasking end of a 2-share Boolean masking datapath: refresh each share
// with fresh randomness into its own register, then XOR the registered shares.
module masked_share_decoder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    masked_share_decoder_if.slave  bus,
    output logic [CNT_W-1:0]       word_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             rdy_en;
    logic             s1_valid;
    logic [WIDTH-1:0] r0q;
    logic [WIDTH-1:0] r1q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;

    logic s2_free_c;
    logic s1_adv_c;
    logic in_ready_c;
    logic accept_c;
    logic out_hs_c;

    // Handshake and pipeline-advance decisions
    always_comb begin
        s2_free_c  = !out_valid_q || bus.out_ready;
        s1_adv_c   = s1_valid && s2_free_c;
        in_ready_c = rdy_en && (!s1_valid || s2_free_c);
        accept_c   = bus.in_valid && in_ready_c;
        out_hs_c   = out_valid_q && bus.out_ready;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // Keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // Stage 1: each share is only ever combined with r before being registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0q      <= '0;
            r1q      <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (accept_c) begin
                r0q <= bus.share0 ^ bus.r;
                r1q <= bus.share1 ^ bus.r;
            end
            if (accept_c) begin
                s1_valid <= 1'b1;
            end else if (s1_adv_c) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: the r terms cancel here, leaving share0 ^ share1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (s1_adv_c) begin
                out_data_q  <= r0q ^ r1q;
                out_valid_q <= 1'b1;
            end else if (out_hs_c) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Saturating count of delivered words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
        end else if (out_hs_c && (word_count != CNT_MAX)) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_masked_share_decoder.sv
// Directed bench for masked_share_decoder: latency, r independence,
// backpressure, simultaneous shift, mid-flight reset and counter saturation.
module tb_masked_share_decoder;

    localparam int unsigned WIDTH = 8;

    logic        clk;
    logic        rst_n;
    logic        rst_s_n;
    logic [15:0] word_count;
    logic [3:0]  word_count_s;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] rtab [4] = '{8'h00, 8'hFF, 8'h5F, 8'h81};
    logic [7:0] tin  [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h14};
    logic       tor  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       trdy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       tov  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] tod  [8] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h12, 8'h13, 8'h14, 8'h00};

    masked_share_decoder_if #(.WIDTH(WIDTH)) bus ();
    masked_share_decoder_if #(.WIDTH(WIDTH)) bus_s ();

    masked_share_decoder #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .word_count (word_count)
    );

    masked_share_decoder #(.WIDTH(WIDTH), .CNT_W(4)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_s_n),
        .bus        (bus_s),
        .word_count (word_count_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] rr);
        bus.in_valid = v;
        bus.share0   = s0;
        bus.share1   = s1;
        bus.r        = rr;
    endtask

    initial begin
        rst_n     = 1'b0;
        rst_s_n   = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        bus.out_ready   = 1'b0;
        bus_s.in_valid  = 1'b0;
        bus_s.share0    = 8'h0F;
        bus_s.share1    = 8'hF0;
        bus_s.r         = 8'hAA;
        bus_s.out_ready = 1'b0;

        // Reset values
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_word_cnt",  32'(word_count),    32'h0);
        #11 rst_n = 1'b1;
        step();
        check("rdy_after_rst", 32'(bus.in_ready), 32'h1);

        // Basic decode: 0xA5 ^ 0x3C = 0x99
        drive(1'b1, 8'hA5, 8'h3C, 8'h5F);
        bus.out_ready = 1'b1;
        step();
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        check("basic_lat1_valid", 32'(bus.out_valid), 32'h0);
        step();
        check("basic_valid", 32'(bus.out_valid), 32'h1);
        check("basic_data",  32'(bus.out_data),  32'h99);
        step();
        check("basic_cnt",   32'(word_count),    32'h1);
        check("basic_drain", 32'(bus.out_valid), 32'h0);

        // Same shares, four different r values, back to back
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1'b1, 8'hA5, 8'h3C, rtab[i]);
            else       drive(1'b0, 8'h00, 8'h00, 8'h00);
            step();
            check($sformatf("rind_valid%0d", i), 32'(bus.out_valid), 32'((i >= 1) && (i <= 4)));
            if ((i >= 1) && (i <= 4)) check($sformatf("rind_data%0d", i), 32'(bus.out_data), 32'h99);
        end
        check("rind_cnt", 32'(word_count), 32'd5);

        // Backpressure: capacity two, third push refused, output held
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h00, 8'h33);
        step();
        check("bp_rdy1", 32'(bus.in_ready), 32'h1);
        drive(1'b1, 8'h02, 8'h00, 8'h44);
        step();
        check("bp_rdy2", 32'(bus.in_ready), 32'h0);
        check("bp_data1", 32'(bus.out_data), 32'h01);
        drive(1'b1, 8'h03, 8'h00, 8'h55);
        step();
        check("bp_rdy3",   32'(bus.in_ready),  32'h0);
        check("bp_valid3", 32'(bus.out_valid), 32'h1);
        check("bp_hold3",  32'(bus.out_data),  32'h01);
        step();
        check("bp_hold4",  32'(bus.out_data),  32'h01);
        bus.out_ready = 1'b1;
        #1;
        check("bp_rdy_comb", 32'(bus.in_ready), 32'h1);
        step();
        check("bp_out2", 32'(bus.out_data), 32'h02);
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        step();
        check("bp_out3",   32'(bus.out_data),  32'h03);
        check("bp_valid5", 32'(bus.out_valid), 32'h1);
        step();
        check("bp_drain",  32'(bus.out_valid), 32'h0);
        check("bp_cnt",    32'(word_count),    32'd8);

        // Continuous input with out_ready toggling 1,0,1,1,0,1
        for (int c = 0; c < 8; c++) begin
            bus.out_ready = tor[c];
            if (c < 6) drive(1'b1, tin[c] ^ 8'hC3, 8'hC3, 8'(c * 17));
            else       drive(1'b0, 8'h00, 8'h00, 8'h00);
            #1;
            check($sformatf("tp_rdy%0d", c), 32'(bus.in_ready), 32'(trdy[c]));
            step();
            check($sformatf("tp_valid%0d", c), 32'(bus.out_valid), 32'(tov[c]));
            if (tov[c]) check($sformatf("tp_data%0d", c), 32'(bus.out_data), 32'(tod[c]));
        end
        check("tp_cnt", 32'(word_count), 32'd13);

        // Reset with both stages occupied
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h77, 8'h00, 8'h12);
        step();
        drive(1'b1, 8'h66, 8'h00, 8'h34);
        step();
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        check("mrst_pre_valid", 32'(bus.out_valid), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 32'(bus.out_valid), 32'h0);
        check("mrst_cnt",       32'(word_count),    32'h0);
        check("mrst_in_ready",  32'(bus.in_ready),  32'h0);
        #2 rst_n = 1'b1;
        step();
        check("mrst_rdy_rel", 32'(bus.in_ready), 32'h1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("mrst_quiet%0d", k), 32'(bus.out_valid), 32'h0);
        end
        drive(1'b1, 8'h5A, 8'h0F, 8'hC8);
        step();
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        step();
        check("mrst_new_valid", 32'(bus.out_valid), 32'h1);
        check("mrst_new_data",  32'(bus.out_data),  32'h55);
        step();
        check("mrst_new_cnt",   32'(word_count),    32'h1);

        // Saturation on the CNT_W=4 instance: 20 handshakes
        bus_s.in_valid  = 1'b1;
        bus_s.out_ready = 1'b1;
        #3 rst_s_n = 1'b1;
        for (int k = 0; k < 23; k++) begin
            step();
            if (k == 3)  check("sat_data",  32'(bus_s.out_data), 32'hFF);
            if (k == 12) check("sat_mid",   32'(word_count_s),   32'd10);
        end
        check("sat_final", 32'(word_count_s), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
